// File: rtl/aes_ctrl_pkg.sv
// Shared constants and types for the AES-128 stream controller.
//   AES_BLK_W      : AES block / key width in bits
//   AES128_LATENCY : cycles from aes_128 input sample to valid output
//   AES_FIFO_DEPTH : default number of output FIFO entries (credits)
package aes_ctrl_pkg;

  localparam int unsigned AES_BLK_W      = 128;
  localparam int unsigned AES128_LATENCY = 21;
  localparam int unsigned AES_FIFO_DEPTH = 32;

  typedef logic [AES_BLK_W-1:0] aes_blk_t;

endpackage

// File: rtl/aes_128_stream_ctrl_if.sv
// Block-stream handshake bundle of the AES-128 stream controller.
//   in_valid/in_ready/in_data/in_tag     : plaintext blocks into the controller
//   out_valid/out_ready/out_data/out_tag : ciphertext blocks out of the controller
// Modports: slave = controller view, master = producer/consumer view.
interface aes_128_stream_ctrl_if
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned TAG_W = 8
) ();

  logic             in_valid;
  logic             in_ready;
  aes_blk_t         in_data;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  aes_blk_t         out_data;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/aes_out_fifo.sv
// First-word fall-through FIFO with a registered output stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write one entry
//   pop, dout  : consume the entry shown on dout (ignored when empty)
//   full       : DEPTH entries held (storage plus output register)
//   empty      : no entry on dout
//   count      : entries held
// Storage holds DEPTH-1 words; the output register is the DEPTH-th slot.
// A word pushed into an empty FIFO becomes visible on dout one cycle later.
module aes_out_fifo #(
  parameter int unsigned WIDTH = 136,
  parameter int unsigned DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned MD = DEPTH - 1;
  localparam int unsigned AW = (MD > 1) ? $clog2(MD) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [MD];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    mem_cnt;
  logic             out_v;
  logic [WIDTH-1:0] out_d;
  logic             pop_q;
  logic             load;

  assign pop_q = pop & out_v;
  // Refill the output register whenever it is empty or being consumed.
  assign load  = (mem_cnt != '0) & (~out_v | pop_q);

  assign dout  = out_d;
  assign empty = ~out_v;
  assign count = mem_cnt + CW'(out_v);
  assign full  = (count == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      out_v   <= 1'b0;
      out_d   <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(MD - 1)) ? '0 : wr_ptr + AW'(1);
      if (load) begin
        rd_ptr <= (rd_ptr == AW'(MD - 1)) ? '0 : rd_ptr + AW'(1);
        out_d  <= mem[rd_ptr];
        out_v  <= 1'b1;
      end else if (pop_q) begin
        out_v  <= 1'b0;
      end
      unique case ({push, load})
        2'b10:   mem_cnt <= mem_cnt + CW'(1);
        2'b01:   mem_cnt <= mem_cnt - CW'(1);
        default: mem_cnt <= mem_cnt;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full))
    else $error("aes_out_fifo: push while full");

endmodule

// File: rtl/aes_128_stream_ctrl.sv
// Sequencing controller around the fixed-latency, non-stallable aes_128 core.
//   clk, rst_n        : clock, asynchronous active-low reset
//   key_we, key_in    : load the AES-128 key register
//   bus (slave)       : in_* plaintext handshake, out_* ciphertext handshake
//   core_state/key    : drive aes_128.state / aes_128.key
//   core_out          : from aes_128.out, LATENCY cycles after sampling
//   inflight, busy    : blocks inside the core plus the output FIFO
// Every accepted block reserves a FIFO slot up front (credit), so the core
// output can always be absorbed regardless of downstream backpressure.
module aes_128_stream_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned LATENCY    = AES128_LATENCY,
  parameter int unsigned FIFO_DEPTH = AES_FIFO_DEPTH,
  parameter int unsigned TAG_W      = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            key_we,
  input  aes_blk_t                        key_in,
  aes_128_stream_ctrl_if.slave            bus,
  output aes_blk_t                        core_state,
  output aes_blk_t                        core_key,
  input  aes_blk_t                        core_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] inflight,
  output logic                            busy
);

  localparam int unsigned IW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [IW-1:0] CREDITS = IW'(FIFO_DEPTH);

  aes_blk_t         key_reg;
  logic             run;
  logic [IW-1:0]    inflight_q;
  logic [LATENCY-1:0] vpipe;
  logic [TAG_W-1:0] tpipe [LATENCY];

  logic             fire_in;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [IW-1:0]    fifo_count;
  logic [AES_BLK_W+TAG_W-1:0] fifo_dout;

  assign pop     = bus.out_valid & bus.out_ready;
  // A pop in the same cycle frees a slot, so a full controller can still
  // accept while draining; run keeps in_ready low until the first edge
  // after reset release.
  assign bus.in_ready = run & ((inflight_q < CREDITS) | pop);
  assign fire_in = bus.in_valid & bus.in_ready;

  assign core_state = fire_in ? bus.in_data : '0;
  assign core_key   = key_reg;

  assign inflight = inflight_q;
  assign busy     = (inflight_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg    <= '0;
      run        <= 1'b0;
      inflight_q <= '0;
      vpipe      <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) tpipe[i] <= '0;
    end else begin
      run <= 1'b1;
      if (key_we) key_reg <= key_in;
      vpipe    <= {vpipe[LATENCY-2:0], fire_in};
      tpipe[0] <= bus.in_tag;
      for (int unsigned i = 1; i < LATENCY; i++) tpipe[i] <= tpipe[i-1];
      unique case ({fire_in, pop})
        2'b10:   inflight_q <= inflight_q + IW'(1);
        2'b01:   inflight_q <= inflight_q - IW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  aes_out_fifo #(
    .WIDTH (AES_BLK_W + TAG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (vpipe[LATENCY-1]),
    .din   ({core_out, tpipe[LATENCY-1]}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.out_valid = ~fifo_empty;
  assign {bus.out_data, bus.out_tag} = fifo_dout;

  a_fifo_within_credit: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_count <= inflight_q) else $error("aes_128_stream_ctrl: FIFO holds more than inflight");
  a_full_means_pipe_empty: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_full |-> !vpipe[LATENCY-1]) else $error("aes_128_stream_ctrl: core output with FIFO full");

endmodule

// File: tb/tb_aes_128_stream_ctrl.sv
module tb_aes_128_stream_ctrl;
  import aes_ctrl_pkg::*;

  localparam int unsigned L  = 21;
  localparam int unsigned D  = 32;
  localparam int unsigned TW = 8;

  localparam logic [127:0] K1  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] P1  = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] C1  = 128'h3925841d_02dc09fb_dc118597_196a0b32;
  localparam logic [127:0] K2  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] P2  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] C2  = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam logic [127:0] CZ  = 128'h66e94bd4_ef8a2c3b_884cfa59_ca342b2e;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         key_we;
  logic [127:0] key_in, core_state, core_key, core_out;
  logic [5:0]   inflight;
  logic         busy;

  aes_128_stream_ctrl_if #(.TAG_W(TW)) bus ();

  aes_128_stream_ctrl #(.LATENCY(L), .FIFO_DEPTH(D), .TAG_W(TW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_we     (key_we),
    .key_in     (key_in),
    .bus        (bus),
    .core_state (core_state),
    .core_key   (core_key),
    .core_out   (core_out),
    .inflight   (inflight),
    .busy       (busy)
  );

  int unsigned checks = 0, passes = 0, cyc = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ---------------- AES-128 reference ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'd1;
      if (x == 0) inv = 8'd0;
      else for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int rd = 0; rd <= 10; rd++) begin
      if (rd > 0) begin
        for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
        s = t;
        if (rd < 10) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
          end
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] ^= w[4*rd+c][31-8*r -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- stand-in aes_128 core (fixed latency) ----------------
  logic [127:0] cpipe [L];
  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) cpipe[i] <= cpipe[i-1];
    cpipe[0] <= aes_enc(core_state, core_key);
  end
  assign core_out = cpipe[L-1];

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [127:0] d;
    logic [7:0]   t;
    int unsigned  avail;
  } exp_t;

  exp_t         q[$];
  int unsigned  m_infl = 0, n_out = 0;
  logic [127:0] m_key = '0;
  bit           started = 0, exp_ov = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete(); m_infl = 0; m_key = '0; started = 0; exp_ov = 0;
    end else begin : mdl
      bit f, p;
      f = bus.in_valid && bus.in_ready;
      p = exp_ov && bus.out_ready;
      if (p) begin void'(q.pop_front()); n_out++; end
      if (f) q.push_back('{aes_enc(bus.in_data, m_key), bus.in_tag, cyc + L + 1});
      if (key_we) m_key = key_in;
      m_infl = m_infl + int'(f) - int'(p);
      started = 1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready",  bus.in_ready, 0);
      chk("rst_inflight",  inflight, 0);
      chk("rst_busy",      busy, 0);
      chk("rst_out_data",  bus.out_data, 0);
      chk("rst_out_tag",   bus.out_tag, 0);
    end else begin
      exp_ov = 0;
      if (q.size() != 0) exp_ov = (cyc >= q[0].avail);
      chk("out_valid", bus.out_valid, exp_ov);
      if (exp_ov) begin
        chk("out_data", bus.out_data, q[0].d);
        chk("out_tag",  bus.out_tag,  q[0].t);
      end
      chk("inflight", inflight, m_infl);
      chk("busy", busy, m_infl != 0);
      chk("in_ready", bus.in_ready, started && (m_infl < D || (exp_ov && bus.out_ready)));
    end
  end

  // ---------------- drivers ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(input logic [127:0] d, input logic [7:0] t, input bit kw,
                      input logic [127:0] k, output int unsigned fcyc);
    bit ok;
    bus.in_valid = 1; bus.in_data = d; bus.in_tag = t;
    key_we = kw; key_in = k;
    fcyc = 0;
    for (int g = 0; g < 500; g++) begin
      @(negedge clk); ok = bus.in_ready;
      @(posedge clk); #1;
      key_we = 0;
      if (ok) begin fcyc = cyc; bus.in_valid = 0; return; end
    end
    bus.in_valid = 0;
    chk("send_timeout", 0, 1);
  endtask

  task automatic expect_out(input logic [127:0] d, input logic [7:0] t, input int unsigned fcyc);
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        chk("lit_out_data", bus.out_data, d);
        chk("lit_out_tag",  bus.out_tag, t);
        chk("lit_latency",  cyc - fcyc, L + 1);
        @(posedge clk); #1;
        return;
      end
    end
    chk("expect_out_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    for (int g = 0; g < 400; g++) begin
      @(negedge clk);
      if (!busy) begin @(posedge clk); #1; return; end
    end
    chk("drain_timeout", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    checks++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    int unsigned f1, f2, f0, acc, n0, bad;
    bit ok;
    bus.in_valid = 0; bus.in_data = '0; bus.in_tag = '0; bus.out_ready = 0;
    key_we = 0; key_in = '0;
    init_sbox();
    chk("model_sbox_00", sbox[0], 8'h63);
    chk("model_sbox_53", sbox[8'h53], 8'hed);
    chk("model_fips_a1", aes_enc(P1, K1), C1);
    chk("model_fips_c1", aes_enc(P2, K2), C2);
    chk("model_zero",    aes_enc('0, '0), CZ);

    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    // 1: single block, literal ciphertext and latency
    bus.out_ready = 1;
    key_we = 1; key_in = K1;
    @(posedge clk); #1;
    key_we = 0;
    send(P1, 8'h5A, 0, '0, f1);
    expect_out(C1, 8'h5A, f1);
    wait_idle();

    // 2: 64 back-to-back blocks
    n0 = n_out;
    send(rnd128(), 8'd0, 0, '0, f0);
    for (int i = 1; i < 64; i++) send(rnd128(), 8'(i), 0, '0, f1);
    chk("t2_no_stall", f1 - f0, 63);
    wait_idle();
    chk("t2_out_count", n_out - n0, 64);

    // 3: backpressure fills exactly D credits
    bus.out_ready = 0;
    acc = 0;
    bus.in_valid = 1; bus.in_data = rnd128(); bus.in_tag = 8'd100;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk); ok = bus.in_ready;
      @(posedge clk); #1;
      if (ok) begin acc++; bus.in_data = rnd128(); bus.in_tag = 8'(100 + acc); end
    end
    bus.in_valid = 0;
    chk("t3_accepts", acc, D);
    chk("t3_inflight", inflight, D);
    chk("t3_in_ready_low", bus.in_ready, 0);

    // 5: pop and fire together at full credit
    bus.out_ready = 1; bus.in_valid = 1; bus.in_data = rnd128(); bus.in_tag = 8'hC5;
    @(negedge clk);
    chk("t5_in_ready", bus.in_ready, 1);
    chk("t5_inflight_before", inflight, D);
    @(posedge clk); #1;
    bus.in_valid = 0; bus.out_ready = 0;
    @(negedge clk);
    chk("t5_inflight_after", inflight, D);
    @(posedge clk); #1;
    bus.out_ready = 1;
    wait_idle();

    // 4: key change in the same cycle as block N
    send(P1, 8'h41, 1, K2, f1);
    send(P2, 8'h42, 0, '0, f2);
    expect_out(C1, 8'h41, f1);
    expect_out(C2, 8'h42, f2);
    wait_idle();

    // 6: reset with 10 blocks in flight
    bus.out_ready = 0;
    for (int i = 0; i < 10; i++) send(rnd128(), 8'(200 + i), 0, '0, f1);
    repeat (2) @(posedge clk);
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    bad = 0;
    for (int c = 0; c < L + 5; c++) begin
      @(negedge clk); if (bus.out_valid) bad++;
    end
    chk("t6_no_stale_valid", bad, 0);
    chk("t6_inflight", inflight, 0);
    @(posedge clk); #1;
    bus.out_ready = 1;
    send('0, 8'h77, 0, '0, f1);
    expect_out(CZ, 8'h77, f1);
    wait_idle();

    // randomized traffic: heavy backpressure then light
    for (int c = 0; c < 1600; c++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.in_data   = rnd128();
      bus.in_tag    = 8'($urandom);
      bus.out_ready = (c < 800) ? (($urandom % 4) == 0) : (($urandom % 5) != 0);
      key_we        = ($urandom % 16) == 0;
      key_in        = rnd128();
      @(posedge clk); #1;
    end
    bus.in_valid = 0; key_we = 0; bus.out_ready = 1;
    wait_idle();
    chk("final_inflight", inflight, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
